// File: rtl/psx_pkg.sv
// Shared constants, state encoding and response-frame helper for the PSX pad responder.
package psx_pkg;

  localparam logic [7:0]  PSX_CMD_START   = 8'h01;
  localparam logic [7:0]  PSX_CMD_POLL    = 8'h42;
  localparam logic [7:0]  PSX_ID_DIGITAL  = 8'h41;
  localparam logic [7:0]  PSX_DATA_START  = 8'h5A;
  localparam int unsigned PSX_FRAME_BYTES = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ACK,
    DONE
  } psx_state_e;

  // Byte idx of the digital-pad response frame; buttons are active-low, low byte first.
  function automatic logic [7:0] psx_resp_byte(input logic [2:0] idx, input logic [15:0] btn);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'hFF;
      3'd1:    b = PSX_ID_DIGITAL;
      3'd2:    b = PSX_DATA_START;
      3'd3:    b = btn[7:0];
      default: b = btn[15:8];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/psx_sync_edge.sv
// Two-flop synchronizer with registered rise/fall strobes for one asynchronous bus pin.
module psx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Strobes compare the two sync stages so they line up with the new level on dout.
  always_comb begin
    rise_d = s1_q & ~s2_q;
    fall_d = ~s1_q & s2_q;
  end

  // Synchronizer and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout = s2_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/psx_pad_responder.sv
// PSX digital-pad responder: shifts a 5-byte frame out on data, collects command
// bytes, and handshakes each byte with ack.
// Optional feature macro: PSX_CMD_CHECK_EN -- abandon the frame (no ack, data held
// high) when byte 0 is not the start command or byte 1 is not the poll command.
module psx_pad_responder
  import psx_pkg::*;
#(
  parameter int unsigned ACK_DELAY = 4,
  parameter int unsigned ACK_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        att,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic [15:0] buttons,
  output logic        data,
  output logic        ack,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(ACK_DELAY + ACK_WIDTH + 1);

  logic att_s, att_rise, att_fall;
  logic pclk_s, pclk_rise, pclk_fall;
  logic cmd_s, cmd_rise, cmd_fall;
  logic unused_sync;

  psx_sync_edge u_sync_att (
    .clk(clk), .rst(rst), .din(att), .dout(att_s), .rise(att_rise), .fall(att_fall)
  );
  psx_sync_edge u_sync_pclk (
    .clk(clk), .rst(rst), .din(psx_clk), .dout(pclk_s), .rise(pclk_rise), .fall(pclk_fall)
  );
  psx_sync_edge u_sync_cmd (
    .clk(clk), .rst(rst), .din(cmd), .dout(cmd_s), .rise(cmd_rise), .fall(cmd_fall)
  );

  assign unused_sync = ^{att_s, pclk_s, cmd_rise, cmd_fall};

  psx_state_e       state_q, state_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [6:0]       rx_sr_q, rx_sr_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic             data_q, data_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      btn_q, btn_d;

  logic [7:0]       cur_byte, nxt_byte, first_byte, rx_next;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cmd_bad;

  assign cur_byte   = psx_resp_byte(byte_idx_q, btn_q);
  assign nxt_byte   = psx_resp_byte(byte_idx_q + 3'd1, btn_q);
  assign first_byte = psx_resp_byte(3'd0, buttons);
  assign rx_next    = {cmd_s, rx_sr_q};
  assign cnt_nxt    = cnt_q + CNT_W'(1);

  // Command-byte screening for the first two bytes of a frame.
`ifdef PSX_CMD_CHECK_EN
  assign cmd_bad = ((byte_idx_q == 3'd0) && (rx_next != PSX_CMD_START)) ||
                   ((byte_idx_q == 3'd1) && (rx_next != PSX_CMD_POLL));
`else
  assign cmd_bad = 1'b0;
`endif

  // Next-state and next-output logic; an att rise outranks any psx_clk edge.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    rx_sr_d    = rx_sr_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    data_d     = data_q;
    ack_d      = 1'b0;
    cnt_d      = cnt_q;
    btn_d      = btn_q;

    if ((state_q != IDLE) && att_rise) begin
      state_d = IDLE;
      data_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (att_fall) begin
            btn_d      = buttons;
            byte_idx_d = 3'd0;
            bit_idx_d  = 3'd0;
            cnt_d      = '0;
            data_d     = first_byte[0];
            state_d    = SHIFT;
          end
        end
        SHIFT: begin
          if (pclk_fall) begin
            data_d = cur_byte[bit_idx_q];
          end else if (pclk_rise) begin
            rx_sr_d = rx_next[7:1];
            if (bit_idx_q == 3'd7) begin
              rx_byte_d  = rx_next;
              rx_valid_d = 1'b1;
              cnt_d      = '0;
              if ((byte_idx_q == 3'(PSX_FRAME_BYTES - 1)) || cmd_bad) begin
                data_d  = 1'b1;
                state_d = DONE;
              end else begin
                state_d = ACK;
              end
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
        ACK: begin
          cnt_d = cnt_nxt;
          if (cnt_nxt >= CNT_W'(ACK_DELAY + ACK_WIDTH)) begin
            byte_idx_d = byte_idx_q + 3'd1;
            bit_idx_d  = 3'd0;
            cnt_d      = '0;
            data_d     = nxt_byte[0];
            state_d    = SHIFT;
          end else begin
            ack_d = (cnt_nxt >= CNT_W'(ACK_DELAY));
          end
        end
        DONE: begin
          data_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
          data_d  = 1'b1;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_idx_q <= 3'd0;
      bit_idx_q  <= 3'd0;
      rx_sr_q    <= 7'd0;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      data_q     <= 1'b1;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      btn_q      <= 16'hFFFF;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      rx_sr_q    <= rx_sr_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      btn_q      <= btn_d;
    end
  end

  assign data     = data_q;
  assign ack      = ack_q;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule
